de_pipe_stage: RTL and testbench

DE_PIPE_STAGE -- requirements
Module: de_pipe_stage

---
 rtl/de_pipe_stage.sv | 126 ++++++++++++
 tb/tb_de_pipe_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/de_pipe_stage.sv
// Decode-to-execute pipeline stage: two-entry elastic register (MAIN + SKID) with
// branch-flush squashing and a saturating count of squashed entries.
module de_pipe_stage #(
  parameter int          XLEN   = 32,
  parameter int          RA_W   = 5,
  parameter logic [6:0]  NOP_OP = 7'h13
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [6:0]      in_opcode_i,
  input  logic [2:0]      in_funct3_i,
  input  logic [RA_W-1:0] in_rs1_i,
  input  logic [RA_W-1:0] in_rs2_i,
  input  logic [RA_W-1:0] in_rd_i,
  input  logic [XLEN-1:0] in_rdata1_i,
  input  logic [XLEN-1:0] in_rdata2_i,
  input  logic [XLEN-1:0] in_offset_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [6:0]      out_opcode_o,
  output logic [2:0]      out_funct3_o,
  output logic [RA_W-1:0] out_rs1_o,
  output logic [RA_W-1:0] out_rs2_o,
  output logic [RA_W-1:0] out_rd_o,
  output logic [XLEN-1:0] out_rdata1_o,
  output logic [XLEN-1:0] out_rdata2_o,
  output logic [XLEN-1:0] out_offset_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [15:0]     flush_cnt_o
);

  localparam int PW = 10 + 3*RA_W + 4*XLEN;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   main_reg, main_next;
  logic [PW-1:0]   skid_reg, skid_next;
  logic [PW-1:0]   in_payload;
  logic            in_ready_reg;
  logic [15:0]     flush_cnt_reg, flush_cnt_next;
  logic            in_fire, out_fire;
  logic [1:0]      held, drop;
  logic [16:0]     cnt_sum;

  assign in_payload = {in_opcode_i, in_funct3_i, in_rs1_i, in_rs2_i, in_rd_i,
                       in_rdata1_i, in_rdata2_i, in_offset_i, in_pc_i};

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = (state_reg != EMPTY);
  assign in_fire     = in_valid_i & in_ready_reg;
  assign out_fire    = out_valid_o & out_ready_i;
  assign flush_cnt_o = flush_cnt_reg;

  // An empty stage presents a NOP bubble with all other fields zeroed.
  assign {out_opcode_o, out_funct3_o, out_rs1_o, out_rs2_o, out_rd_o,
          out_rdata1_o, out_rdata2_o, out_offset_o, out_pc_o} =
         out_valid_o ? main_reg : {NOP_OP, {(PW-7){1'b0}}};

  always_comb begin
    state_next     = state_reg;
    main_next      = main_reg;
    skid_next      = skid_reg;
    flush_cnt_next = flush_cnt_reg;
    held           = 2'd0;
    drop           = 2'd0;
    cnt_sum        = 17'd0;

    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          main_next  = in_payload;
          state_next = ONE;
        end
      end
      ONE: begin
        held = 2'd1;
        if (in_fire && out_fire) begin
          main_next = in_payload;
        end else if (in_fire) begin
          skid_next  = in_payload;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        held = 2'd2;
        if (out_fire) begin
          main_next  = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Entries delivered to execute this cycle are not squashed; accepted ones are.
    if (flush_i) begin
      state_next     = EMPTY;
      drop           = held - {1'b0, out_fire} + {1'b0, in_fire};
      cnt_sum        = {1'b0, flush_cnt_reg} + {15'd0, drop};
      flush_cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      main_reg      <= '0;
      skid_reg      <= '0;
      flush_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != FULL);
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

endmodule

// File: tb/tb_de_pipe_stage.sv
// Directed bench for de_pipe_stage: handshake ordering, skid behaviour, flush counting
// with saturation, and reset priority.
module tb_de_pipe_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [6:0]      in_opcode_i = '0;
  logic [2:0]      in_funct3_i = '0;
  logic [RA_W-1:0] in_rs1_i = '0, in_rs2_i = '0, in_rd_i = '0;
  logic [XLEN-1:0] in_rdata1_i = '0, in_rdata2_i = '0, in_offset_i = '0, in_pc_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [6:0]      out_opcode_o;
  logic [2:0]      out_funct3_o;
  logic [RA_W-1:0] out_rs1_o, out_rs2_o, out_rd_o;
  logic [XLEN-1:0] out_rdata1_o, out_rdata2_o, out_offset_o, out_pc_o;
  logic [15:0]     flush_cnt_o;

  int checks = 0;
  int failures = 0;

  de_pipe_stage #(.XLEN(XLEN), .RA_W(RA_W), .NOP_OP(7'h13)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_opcode_i(in_opcode_i), .in_funct3_i(in_funct3_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i),
    .in_rdata1_i(in_rdata1_i), .in_rdata2_i(in_rdata2_i),
    .in_offset_i(in_offset_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_opcode_o(out_opcode_o), .out_funct3_o(out_funct3_o),
    .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_rd_o(out_rd_o),
    .out_rdata1_o(out_rdata1_o), .out_rdata2_o(out_rdata2_o),
    .out_offset_o(out_offset_o), .out_pc_o(out_pc_o),
    .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every field of an entry is derived from a small tag so order can be verified.
  task automatic drive(input logic v, input logic [4:0] tag);
    in_valid_i  = v;
    in_opcode_i = 7'h33;
    in_funct3_i = tag[2:0];
    in_rs1_i    = tag ^ 5'h1F;
    in_rs2_i    = tag + 5'd1;
    in_rd_i     = tag;
    in_rdata1_i = 32'hA000_0000 | {27'd0, tag};
    in_rdata2_i = 32'hB000_0000 | {27'd0, tag};
    in_offset_i = 32'hFFFF_FF00 | {27'd0, tag};
    in_pc_i     = 32'h0000_1000 + {25'd0, tag, 2'b00};
  endtask

  task automatic chk_entry(input string tag, input logic [4:0] t);
    chk({tag, ".valid"}, {31'd0, out_valid_o}, 32'd1);
    chk({tag, ".opcode"}, {25'd0, out_opcode_o}, 32'h33);
    chk({tag, ".rd"}, {27'd0, out_rd_o}, {27'd0, t});
    chk({tag, ".rdata2"}, out_rdata2_o, 32'hB000_0000 | {27'd0, t});
    chk({tag, ".pc"}, out_pc_o, 32'h0000_1000 + {25'd0, t, 2'b00});
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, ".opcode"}, {25'd0, out_opcode_o}, 32'h13);
    chk({tag, ".rd"}, {27'd0, out_rd_o}, 32'd0);
    chk({tag, ".rdata1"}, out_rdata1_o, 32'd0);
    chk({tag, ".pc"}, out_pc_o, 32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_bubble("reset");
    chk("reset.in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("reset.flush_cnt", {16'd0, flush_cnt_o}, 32'd0);
    rst_i = 1'b0;
    $display("txn reset done");

    // Single entry, one-cycle latency
    drive(1'b1, 5'd5); out_ready_i = 1'b1;
    tick();
    chk_entry("lat1", 5'd5);
    drive(1'b0, 5'd0);
    tick();
    chk_bubble("lat1_drain");
    $display("txn latency entry rd=5");

    // A,B,C with back-pressure after A
    drive(1'b1, 5'd1); out_ready_i = 1'b1;
    tick();
    chk_entry("A_out", 5'd1);
    chk("A.in_ready", {31'd0, in_ready_o}, 32'd1);
    drive(1'b1, 5'd2); out_ready_i = 1'b0;
    tick();
    chk_entry("A_held", 5'd1);
    chk("full.in_ready", {31'd0, in_ready_o}, 32'd0);
    drive(1'b1, 5'd3);
    tick();
    chk_entry("A_still", 5'd1);
    chk("C_blocked.in_ready", {31'd0, in_ready_o}, 32'd0);
    out_ready_i = 1'b1;
    tick();
    chk_entry("B_out", 5'd2);
    chk("B.in_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    chk_entry("C_out", 5'd3);
    drive(1'b0, 5'd0);
    tick();
    chk_bubble("abc_drain");
    chk("abc.flush_cnt", {16'd0, flush_cnt_o}, 32'd0);
    $display("txn stream A,B,C order checked");

    // Flush in FULL with a blocked input: 2 squashed
    out_ready_i = 1'b0;
    drive(1'b1, 5'd4); tick();
    drive(1'b1, 5'd6); tick();
    chk("fill.in_ready", {31'd0, in_ready_o}, 32'd0);
    drive(1'b1, 5'd7); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; drive(1'b0, 5'd0);
    chk_bubble("flush_full");
    chk("flush_full.cnt", {16'd0, flush_cnt_o}, 32'd2);
    chk("flush_full.in_ready", {31'd0, in_ready_o}, 32'd1);
    $display("txn flush FULL cnt=%0d", flush_cnt_o);

    // ONE with IN_FIRE, OUT_FIRE and flush: +1
    out_ready_i = 1'b1;
    drive(1'b1, 5'd8); tick();
    drive(1'b1, 5'd9); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; drive(1'b0, 5'd0);
    chk("flush_one.valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_one.cnt", {16'd0, flush_cnt_o}, 32'd3);
    $display("txn flush ONE cnt=%0d", flush_cnt_o);

    // EMPTY with IN_FIRE and flush: +1
    drive(1'b1, 5'd10); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; drive(1'b0, 5'd0);
    chk("flush_empty.valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_empty.cnt", {16'd0, flush_cnt_o}, 32'd4);
    $display("txn flush EMPTY cnt=%0d", flush_cnt_o);

    // FULL with OUT_FIRE and flush: delivered entry not counted, +1
    out_ready_i = 1'b0;
    drive(1'b1, 5'd11); tick();
    drive(1'b1, 5'd12); tick();
    drive(1'b1, 5'd13); out_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; drive(1'b0, 5'd0);
    chk("flush_full_out.cnt", {16'd0, flush_cnt_o}, 32'd5);
    $display("txn flush FULL+OUT cnt=%0d", flush_cnt_o);

    // Preload to 16'hFFFE: each flushed EMPTY+IN_FIRE cycle adds one
    out_ready_i = 1'b0;
    drive(1'b1, 5'd14); flush_i = 1'b1;
    for (int i = 0; i < 65529; i++) tick();
    flush_i = 1'b0; drive(1'b0, 5'd0);
    chk("preload.cnt", {16'd0, flush_cnt_o}, 32'h0000_FFFE);
    $display("txn preload cnt=%0h", flush_cnt_o);

    drive(1'b1, 5'd15); tick();
    drive(1'b1, 5'd16); tick();
    flush_i = 1'b1; drive(1'b0, 5'd0);
    tick();
    flush_i = 1'b0;
    chk("saturate.cnt", {16'd0, flush_cnt_o}, 32'h0000_FFFF);
    drive(1'b1, 5'd17); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; drive(1'b0, 5'd0);
    chk("saturate_hold.cnt", {16'd0, flush_cnt_o}, 32'h0000_FFFF);
    $display("txn saturate cnt=%0h", flush_cnt_o);

    // Reset while FULL, overriding flush and handshakes
    out_ready_i = 1'b0;
    drive(1'b1, 5'd18); tick();
    drive(1'b1, 5'd19); tick();
    chk_entry("pre_rst", 5'd18);
    rst_i = 1'b1; flush_i = 1'b1;
    tick();
    rst_i = 1'b0; flush_i = 1'b0; drive(1'b0, 5'd0);
    chk_bubble("rst_full");
    chk("rst_full.in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_full.cnt", {16'd0, flush_cnt_o}, 32'd0);
    $display("txn reset in FULL");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
